// File: rtl/button_event_unit.sv
// button_event_unit
//   Synchronises and debounces a raw push-button and turns each accepted
//   press into a sticky pending event. The event is held until it is
//   consumed with ack. The debounced level and a wrapping press counter
//   are also exported.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     When defined, holding the button in the pressed state raises a new
//     event (and counts a press) every REPEAT_CYCLES cycles.
//
// Ports
//   clock        in   1        system clock, all state on rising edge
//   reset        in   1        asynchronous, active-high; clears all state
//   btn_raw      in   1        raw asynchronous button pin, 1 = pressed
//   ack          in   1        pending event consumed this cycle
//   button       out  1        pending press event, sticky until ack
//   btn_level    out  1        debounced button level
//   press_count  out  PRESS_W  accepted presses, wraps at 2^PRESS_W
module button_event_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned PRESS_W         = 16,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_raw,
  input  logic               ack,
  output logic               button,
  output logic               btn_level,
  output logic [PRESS_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync2_q;
  logic               btn_sync;
  logic               level_d;
  logic               button_d;
  logic [PRESS_W-1:0] count_d;
  logic               accept;

  assign btn_sync = sync2_q;

  // Two-flop synchroniser; the only reader of btn_raw
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next-state logic; accept flags a new press event
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = btn_level;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          // Bounce back to pressed: no new event
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             repeat_fire;

  // Repeat timer runs only while staying in PRESSED; zero on entry and exit
  always_comb begin
    rpt_d       = '0;
    repeat_fire = 1'b0;
    if (state_q == PRESSED && state_d == PRESSED) begin
      if (rpt_q == RPT_LAST) begin
        rpt_d       = '0;
        repeat_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  logic repeat_fire;
  assign repeat_fire = 1'b0;
`endif

  // Event handshake: a new event on the ack edge wins over the clear
  always_comb begin
    button_d = (accept | repeat_fire) | (button & ~ack);
    count_d  = press_count + PRESS_W'(accept | repeat_fire);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      button      <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      button      <= button_d;
      btn_level   <= level_d;
      press_count <= count_d;
    end
  end

endmodule

// File: tb/tb_button_event_unit.sv
// tb_button_event_unit
//   Directed bench for button_event_unit with DEBOUNCE_CYCLES=4, PRESS_W=4,
//   REPEAT_CYCLES=8. Outputs are sampled 1 time unit after each rising edge.
module tb_button_event_unit;

  localparam int unsigned DEB   = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned PW    = 4;
  localparam int unsigned RPT   = 8;

  logic          clock;
  logic          reset;
  logic          btn_raw;
  logic          ack;
  logic          button;
  logic          btn_level;
  logic [PW-1:0] press_count;

  int n_checks;
  int n_pass;

  button_event_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CW),
    .PRESS_W(PW),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_raw(btn_raw),
    .ack(ack),
    .button(button),
    .btn_level(btn_level),
    .press_count(press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int exp_cnt;
    int pulses;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    btn_raw  = 1'b0;
    ack      = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_button", 32'(button), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_count", 32'(press_count), 32'd0);

    // Clean press: event appears after edge 7
    btn_raw = 1'b1;
    tick(6);
    check("press_e6_button", 32'(button), 32'd0);
    tick(1);
    check("press_e7_button", 32'(button), 32'd1);
    check("press_e7_level", 32'(btn_level), 32'd1);
    check("press_e7_count", 32'(press_count), 32'd1);

    // Ack clears; ack while idle ignored
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_clear", 32'(button), 32'd0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_idle", 32'(button), 32'd0);
    check("ack_level_held", 32'(btn_level), 32'd1);

    // Release debounce
    btn_raw = 1'b0;
    tick(6);
    check("rel_e6_level", 32'(btn_level), 32'd1);
    tick(1);
    check("rel_e7_level", 32'(btn_level), 32'd0);
    check("rel_count", 32'(press_count), 32'd1);

    // Short glitch of 3 cycles: no event
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(10);
    check("glitch_button", 32'(button), 32'd0);
    check("glitch_count", 32'(press_count), 32'd1);
    check("glitch_level", 32'(btn_level), 32'd0);

    // Accept and ack on the same edge: set wins
    btn_raw = 1'b1;
    tick(6);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("setwin_button", 32'(button), 32'd1);
    check("setwin_count", 32'(press_count), 32'd2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("setwin_ack", 32'(button), 32'd0);
    btn_raw = 1'b0;
    tick(7);

    // Press, then a 1-cycle bounce during release debounce
    btn_raw = 1'b1;
    tick(7);
    check("bounce_press_count", 32'(press_count), 32'd3);
    btn_raw = 1'b0;
    tick(4);
    btn_raw = 1'b1;
    tick(1);
    btn_raw = 1'b0;
    tick(12);
    check("bounce_count", 32'(press_count), 32'd3);
    check("bounce_level", 32'(btn_level), 32'd0);

    // 13 more clean presses wrap the 4-bit counter back to 0
    exp_cnt = 3;
    for (int i = 0; i < 13; i++) begin
      btn_raw = 1'b1;
      tick(7);
      exp_cnt = (exp_cnt + 1) % 16;
      check("wrap_count", 32'(press_count), 32'(exp_cnt));
      btn_raw = 1'b0;
      tick(7);
    end
    check("wrap_zero", 32'(press_count), 32'd0);
    check("wrap_button_sticky", 32'(button), 32'd1);

    // One more press, then reset mid-PRESS_WAIT with event pending
    btn_raw = 1'b1;
    tick(7);
    check("pre_rst_count", 32'(press_count), 32'd1);
    btn_raw = 1'b0;
    tick(7);
    btn_raw = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    check("midrst_button", 32'(button), 32'd0);
    check("midrst_level", 32'(btn_level), 32'd0);
    check("midrst_count", 32'(press_count), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(6);
    check("postrst_e6_button", 32'(button), 32'd0);
    tick(1);
    check("postrst_e7_button", 32'(button), 32'd1);
    check("postrst_e7_count", 32'(press_count), 32'd1);

    // Hold 30 cycles with ack every cycle
    ack    = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
`ifdef BTN_AUTOREPEAT_EN
      check("rpt_pulse", 32'(button), ((k % 8) == 0) ? 32'd1 : 32'd0);
`else
      check("rpt_pulse", 32'(button), 32'd0);
`endif
      if (button) pulses++;
    end
    ack = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    check("rpt_pulses", 32'(pulses), 32'd3);
    check("rpt_count", 32'(press_count), 32'd4);
`else
    check("rpt_pulses", 32'(pulses), 32'd0);
    check("rpt_count", 32'(press_count), 32'd1);
`endif
    check("rpt_level", 32'(btn_level), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
